single_port_sram_32bit: RTL and testbench
=========================================

Name: single_port_sram_32bit

Overview:
Synchronous single-port static RAM, 256 words x 32 bits, on one shared address bus. Writes and reads are selected by separate enables. The read data output is registered. Used as a general-purpose scratch and data store behind a simple enable-based master, with no handshake.

Parameters:
DATA_WIDTH, 32, word width in bits for Data_In, Data_Out and the storage array.
ADDR_WIDTH, 8, address width in bits.
DEPTH, 256, number of words; must equal 2**ADDR_WIDTH.

Ports:
Clk_In  input  1  clock; all state updates on its rising edge.
Reset_In  input  1  asynchronous, active-low reset (0 = reset asserted).
Data_In  input  DATA_WIDTH  write data.
Address_In  input  ADDR_WIDTH  word address shared by read and write.
Data_Out  output  DATA_WIDTH  registered read data.
Write_Enable  input  1  write strobe, active-high.
Read_Enable  input  1  read strobe, active-high.

Behaviour:
- Storage: DEPTH x DATA_WIDTH array plus one valid bit per word.
- Reset (Reset_In=0), asynchronous, effective immediately without a clock edge:
  - Data_Out = 0.
  - All valid bits = 0.
  - Array contents need not be cleared.
  - While reset is held, writes and reads are ignored.
- Reset release: first active edge is the first rising Clk_In with Reset_In=1.
- Write (Write_Enable=1 at rising edge): mem[Address_In] <= Data_In; valid[Address_In] <= 1. Last write to an address wins.
- Read (Read_Enable=1, Write_Enable=0 at rising edge): Data_Out <= mem[Address_In] if valid[Address_In]=1, else 0.
  - Latency is one cycle: data is visible after the same edge that samples the address.
- Idle (both enables 0): Data_Out holds its last value; memory unchanged.
- Both enables 1 at the same edge: the write is performed. Data_Out behaviour depends on the optional feature below.
- Address_In always selects a valid word (full decode); there is no out-of-range or wrap case.
- Reset asserted mid-sequence:
  - A write in flight at the reset edge is discarded.
  - Data_Out returns to 0 and all words read as 0 until rewritten.
- No X on Data_Out after reset under any enable combination.

Optional Feature:
Macro SPSRAM_WRITE_THROUGH_EN.
- Defined: when Write_Enable=1 and Read_Enable=1 at the same edge, the write happens and Data_Out <= Data_In (write-through, new data).
- Not defined: in that case the write happens and Data_Out holds its previous value. No read is performed.

Test Plan:
- Reset: hold Reset_In=0, then release. Data_Out=0 immediately on assertion. A read of address 0x00 after release returns 0 (unwritten word).
- Write/read: write 0x12345678 @0x24, then next cycle read @0x24 -> Data_Out=0x12345678 one edge after the read strobe.
- Overwrite and hold:
  - Write 0xDEADBEEF @0xFF, then 0x0BADF00D @0xFF; read @0xFF -> 0x0BADF00D.
  - Then 3 idle cycles -> Data_Out stays 0x0BADF00D.
- Alternating random: 20 iterations of write(random data, random addr) followed by read(same addr) -> each read matches the data just written. A later read of an untouched address returns 0.
- Simultaneous enables: mem[0x10]=0xAAAA5555, Data_Out=0x11111111. Assert both enables with Data_In=0x5A5A5A5A @0x10:
  - Without macro: Data_Out stays 0x11111111.
  - With macro: Data_Out=0x5A5A5A5A.
  - Either way, a subsequent read @0x10 returns 0x5A5A5A5A.
- Reset mid-operation: write 0xCAFEBABE @0x33, assert Reset_In=0 between clock edges -> Data_Out=0 at once. After release, a read @0x33 returns 0.

Source files
------------

// File: rtl/single_port_sram_32bit.sv
// -----------------------------------------------------------------------------
// single_port_sram_32bit
//
// Synchronous single-port RAM, DEPTH words x DATA_WIDTH bits, with one shared
// address bus. Writes and reads use separate active-high strobes. The read
// data output is registered, so it appears one clock after the read strobe.
// Each word carries a valid bit. An unwritten word, or a word not rewritten
// since the last reset, reads as zero.
//
// Optional feature (compile-time macro SPSRAM_WRITE_THROUGH_EN):
//   When this macro is defined and both strobes are high at the same edge,
//   the write happens and Data_Out takes the new write data.
//   When this macro is undefined, the write happens and Data_Out holds its
//   previous value.
//
// Ports:
//   Clk_In        in   1           clock; all state changes on its rising edge
//   Reset_In      in   1           asynchronous reset, active-low
//   Data_In       in   DATA_WIDTH  write data
//   Address_In    in   ADDR_WIDTH  word address, shared by read and write
//   Data_Out      out  DATA_WIDTH  registered read data
//   Write_Enable  in   1           write strobe, active-high
//   Read_Enable   in   1           read strobe, active-high
// -----------------------------------------------------------------------------
module single_port_sram_32bit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic [ADDR_WIDTH-1:0] Address_In,
    output logic [DATA_WIDTH-1:0] Data_Out,
    input  logic                  Write_Enable,
    input  logic                  Read_Enable
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] w_read_word;

    // A word that has never been written since reset reads as zero. The
    // array itself is never cleared.
    assign w_read_word = r_valid[Address_In] ? r_mem[Address_In] : '0;

    // The storage array has no reset. A write landing here while reset is
    // held cannot be seen later, because the valid bit for that word stays
    // clear until the word is rewritten after reset release.
    always_ff @(posedge Clk_In) begin
        if (Write_Enable) begin
            r_mem[Address_In] <= Data_In;
        end
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            r_valid <= '0;
        end else if (Write_Enable) begin
            r_valid[Address_In] <= 1'b1;
        end
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            r_data_out <= '0;
        end else if (Write_Enable && Read_Enable) begin
`ifdef SPSRAM_WRITE_THROUGH_EN
            r_data_out <= Data_In;
`else
            r_data_out <= r_data_out;
`endif
        end else if (Read_Enable) begin
            r_data_out <= w_read_word;
        end
    end

    assign Data_Out = r_data_out;

endmodule

// File: tb/tb_single_port_sram_32bit.sv
// -----------------------------------------------------------------------------
// tb_single_port_sram_32bit
//
// Self-checking bench for single_port_sram_32bit. A reference model built from
// plain arrays predicts Data_Out, and the observed value is checked with an
// immediate assertion after each clock. Build with SPSRAM_WRITE_THROUGH_EN
// defined to exercise the write-through variant.
// -----------------------------------------------------------------------------
module tb_single_port_sram_32bit;

    logic        Clk_In = 1'b0;
    logic        Reset_In = 1'b1;
    logic [31:0] Data_In = '0;
    logic [7:0]  Address_In = '0;
    logic [31:0] Data_Out;
    logic        Write_Enable = 1'b0;
    logic        Read_Enable = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference model: memory contents, valid-since-reset flags, expected output.
    logic [31:0] m_mem [256];
    bit          m_vld [256];
    logic [31:0] m_out;

    single_port_sram_32bit dut (
        .Clk_In       (Clk_In),
        .Reset_In     (Reset_In),
        .Data_In      (Data_In),
        .Address_In   (Address_In),
        .Data_Out     (Data_Out),
        .Write_Enable (Write_Enable),
        .Read_Enable  (Read_Enable)
    );

    always #5 Clk_In = ~Clk_In;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_vld[i] = 1'b0;
        m_out = '0;
    endtask

    // Apply one set of inputs for one clock, update the model, and return at
    // the following falling edge so that outputs are sampled away from posedge.
    task automatic cycle(input bit we, input bit re, input logic [7:0] a, input logic [31:0] d);
        Write_Enable = we;
        Read_Enable  = re;
        Address_In   = a;
        Data_In      = d;
        @(posedge Clk_In);
        if (we && re) begin
`ifdef SPSRAM_WRITE_THROUGH_EN
            m_out = d;
`endif
        end else if (re) begin
            m_out = m_vld[a] ? m_mem[a] : 32'h0;
        end
        if (we) begin
            m_mem[a] = d;
            m_vld[a] = 1'b1;
        end
        @(negedge Clk_In);
        Write_Enable = 1'b0;
        Read_Enable  = 1'b0;
    endtask

    initial begin
        logic [7:0]  ra;
        logic [31:0] rd;
        logic [7:0]  ua;
        int          guard;

        model_clear();

        // Reset asserted: the output must clear at once, without a clock edge.
        #3 Reset_In = 1'b0;
        #1 check("reset_immediate", Data_Out, 32'h0);
        // A write strobe held during reset must be ignored.
        Write_Enable = 1'b1; Address_In = 8'h00; Data_In = 32'hFFFF_FFFF;
        @(posedge Clk_In);
        @(negedge Clk_In);
        Write_Enable = 1'b0;
        check("reset_held", Data_Out, 32'h0);
        Reset_In = 1'b1;

        cycle(1'b0, 1'b1, 8'h00, 32'h0);
        check("read_unwritten_0", Data_Out, m_out);
        check("read_unwritten_0_abs", Data_Out, 32'h0);

        // Basic write followed by read.
        cycle(1'b1, 1'b0, 8'h24, 32'h1234_5678);
        check("write_no_read_hold", Data_Out, m_out);
        cycle(1'b0, 1'b1, 8'h24, 32'h0);
        check("read_24", Data_Out, 32'h1234_5678);

        // Overwrite: the last write wins. Then idle cycles hold the output.
        cycle(1'b1, 1'b0, 8'hFF, 32'hDEAD_BEEF);
        cycle(1'b1, 1'b0, 8'hFF, 32'h0BAD_F00D);
        cycle(1'b0, 1'b1, 8'hFF, 32'h0);
        check("read_ff_overwrite", Data_Out, 32'h0BAD_F00D);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'($urandom), $urandom);
            check($sformatf("idle_hold_%0d", i), Data_Out, 32'h0BAD_F00D);
        end

        // Alternating random write and read of the same address.
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rd = $urandom;
            cycle(1'b1, 1'b0, ra, rd);
            cycle(1'b0, 1'b1, ra, $urandom);
            check($sformatf("rand_rd_%0d", i), Data_Out, m_out);
        end

        // Read an address that no write has touched.
        ua = 8'($urandom);
        guard = 0;
        while (m_vld[ua] && guard < 1000) begin
            ua = 8'($urandom);
            guard++;
        end
        cycle(1'b0, 1'b1, ua, 32'h0);
        check("read_untouched", Data_Out, 32'h0);

        // Assert both strobes in the same cycle.
        cycle(1'b1, 1'b0, 8'h10, 32'hAAAA_5555);
        cycle(1'b1, 1'b0, 8'h20, 32'h1111_1111);
        cycle(1'b0, 1'b1, 8'h20, 32'h0);
        check("preload_out", Data_Out, 32'h1111_1111);
        cycle(1'b1, 1'b1, 8'h10, 32'h5A5A_5A5A);
`ifdef SPSRAM_WRITE_THROUGH_EN
        check("both_en_out", Data_Out, 32'h5A5A_5A5A);
`else
        check("both_en_out", Data_Out, 32'h1111_1111);
`endif
        check("both_en_model", Data_Out, m_out);
        cycle(1'b0, 1'b1, 8'h10, 32'h0);
        check("read_after_both", Data_Out, 32'h5A5A_5A5A);

        // Assert reset between clock edges. The output clears at once, and
        // all words read as zero afterwards.
        cycle(1'b1, 1'b0, 8'h33, 32'hCAFE_BABE);
        cycle(1'b0, 1'b1, 8'h33, 32'h0);
        check("pre_reset_read_33", Data_Out, 32'hCAFE_BABE);
        #2 Reset_In = 1'b0;
        #1 check("reset_mid_immediate", Data_Out, 32'h0);
        model_clear();
        // A write in flight at an edge during reset must be discarded.
        Write_Enable = 1'b1; Address_In = 8'h44; Data_In = 32'h7777_7777;
        @(posedge Clk_In);
        @(negedge Clk_In);
        Write_Enable = 1'b0;
        Reset_In = 1'b1;
        cycle(1'b0, 1'b1, 8'h33, 32'h0);
        check("read_33_after_reset", Data_Out, 32'h0);
        cycle(1'b0, 1'b1, 8'h44, 32'h0);
        check("read_44_discarded", Data_Out, 32'h0);
        cycle(1'b0, 1'b1, 8'h24, 32'h0);
        check("read_24_after_reset", Data_Out, m_out);
        cycle(1'b1, 1'b0, 8'h33, 32'h0102_0304);
        cycle(1'b0, 1'b1, 8'h33, 32'h0);
        check("rewrite_33", Data_Out, 32'h0102_0304);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound so the run always ends by itself.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
